// File: rtl/sc_ctrl_pkg.sv
// Shared definitions for the sc_ctrl scheduler: FSM state encoding, counter
// width/limit and a target legality helper.
package sc_ctrl_pkg;
   localparam int SC_W = 3;
   localparam logic [SC_W-1:0] SC_MAX = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   // A target is usable only if sc can actually reach it (1..SC_MAX).
   function automatic logic tgt_legal(input logic [SC_W-1:0] t);
      return (t != '0) && (t <= SC_MAX);
   endfunction
endpackage

// File: rtl/sc_ctrl_if.sv
// Bundle between sc_ctrl and its surroundings.
//   req/target : requester side, driven by the requesters
//   gnt/done/busy/err : status back to requesters
//   cnt_in/cnt_err : observed from sc; ctr_rst : drives sc
// master = requesters + sc side, slave = sc_ctrl.
interface sc_ctrl_if import sc_ctrl_pkg::*; #(parameter int N_REQ = 4);
   logic [N_REQ-1:0]      req;
   logic [SC_W*N_REQ-1:0] target;
   logic [SC_W-1:0]       cnt_in;
   logic                  cnt_err;
   logic                  ctr_rst;
   logic [N_REQ-1:0]      gnt;
   logic                  done;
   logic                  busy;
   logic                  err;

   modport master (output req, target, cnt_in, cnt_err,
                   input  ctr_rst, gnt, done, busy, err);
   modport slave  (input  req, target, cnt_in, cnt_err,
                   output ctr_rst, gnt, done, busy, err);
endinterface

// File: rtl/sc_ctrl_rr_arb.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index with highest priority this round
//   win     : one-hot winner (zero if no request)
//   win_idx : binary index of the winner
module sc_ctrl_rr_arb #(
   parameter int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] win,
   output logic [IDX_W-1:0] win_idx
);
   int j;

   // Scan from the farthest offset back toward ptr so that the closest
   // requester (in ptr, ptr+1, ... order) is the last one written.
   always_comb begin
      win     = '0;
      win_idx = '0;
      j       = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (req[IDX_W'(j)]) begin
            win              = '0;
            win[IDX_W'(j)]   = 1'b1;
            win_idx          = IDX_W'(j);
         end
      end
   end
endmodule

// File: rtl/sc_ctrl.sv
// Round-robin sequencer for one shared saturating counter sc.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sc_ctrl_if slave (req/target in, gnt/done/busy/err out,
//              cnt_in/cnt_err from sc, ctr_rst to sc)
// One session per grant: sc is held cleared outside COUNT, released in COUNT,
// and the session ends on cnt_in==tgt (DONE), on requester abort (IDLE), or
// on watchdog / sc error (ERR, absorbing until rst).
module sc_ctrl import sc_ctrl_pkg::*; #(
   parameter int N_REQ    = 4,
   parameter int WD_LIMIT = 7
) (
   input logic     clk,
   input logic     rst,
   sc_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(N_REQ);
   localparam int WD_W  = $clog2(WD_LIMIT + 1);

   state_t                      state_q, state_d;
   logic [N_REQ-1:0]            gnt_q, gnt_d;
   logic [SC_W-1:0]             tgt_q, tgt_d;
   logic [IDX_W-1:0]            ptr_q, ptr_d;
   logic [WD_W-1:0]             wd_q, wd_d;

   logic [N_REQ-1:0]            win;
   logic [IDX_W-1:0]            win_idx;
   logic [N_REQ-1:0][SC_W-1:0]  tgt_arr;

   assign tgt_arr = bus.target;

   sc_ctrl_rr_arb #(.N_REQ(N_REQ)) u_rr_arb (
      .req     (bus.req),
      .ptr     (ptr_q),
      .win     (win),
      .win_idx (win_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         tgt_q   <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         tgt_q   <= tgt_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      tgt_d   = tgt_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               tgt_d = tgt_arr[win_idx];
               ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
               if (tgt_legal(tgt_arr[win_idx])) begin
                  state_d = ST_COUNT;
                  gnt_d   = win;
                  wd_d    = '0;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_COUNT: begin
            // wd holds COUNT cycles already elapsed, so the WD_LIMIT-th
            // cycle without a match is the last one before ERR.
            wd_d = wd_q + WD_W'(1);
            if ((bus.req & gnt_q) == '0) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else if (bus.cnt_in == tgt_q) begin
               state_d = ST_DONE;
            end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
               state_d = ST_ERR;
               gnt_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
         default: begin
            gnt_d = '0;
         end
      endcase
      // sc error overrides every other decision.
      if (bus.cnt_err) begin
         state_d = ST_ERR;
         gnt_d   = '0;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.done    = (state_q == ST_DONE);
   assign bus.busy    = (state_q == ST_COUNT) || (state_q == ST_DONE);
   assign bus.err     = (state_q == ST_ERR);
   assign bus.ctr_rst = (state_q != ST_COUNT);
endmodule
